alu_vec_pipe: RTL and testbench
===============================

# alu_vec_pipe

Parametrised, pipelined successor to the single-lane vector ALU. It processes `LANES` independent signed lanes of `WIDTH` bits per transaction over a two-stage valid/ready pipeline, producing per-lane flags and a sticky overflow summary. It sits between the vector register-file read port and the writeback stage of the SIMD datapath.

## Interface
- `WIDTH`, default 8: lane width in bits, two's complement, minimum 4.
- `LANES`, default 4: lane count, minimum 1.
- `clk` input 1: clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: the request is valid.
- `in_ready` output 1: the ALU accepts a request this cycle.
- `opcode` input 3: operation, identical for all lanes.
- `vec_a` input `LANES*WIDTH`: operand A; lane i occupies `[i*WIDTH +: WIDTH]`.
- `vec_b` input `LANES*WIDTH`: operand B, same packing.
- `scalar_c` input `WIDTH`: broadcast value for `set`.
- `out_valid` output 1: the result is valid.
- `out_ready` input 1: the consumer accepts the result.
- `result` output `LANES*WIDTH`: per-lane result.
- `flags` output `LANES*4`: per-lane `{V,N,Z,C}`, with lane i at `[i*4 +: 4]`.
- `sticky_v` output 1: OR of V across all lanes of every completed transaction since the last clear.
- `sticky_clr` input 1: synchronous clear of `sticky_v`.

## Operation
- Opcodes:
  - 000 mul: low `WIDTH` bits of the signed product.
  - 001 sub: a-b.
  - 010 add: a+b.
  - 011 shl: a << b[$clog2(WIDTH)-1:0].
  - 100 sra: arithmetic a >> b[$clog2(WIDTH)-1:0].
  - 101 min: signed minimum.
  - 110 max: signed maximum.
  - 111 set: every lane = `scalar_c`.
- Flag N: sign bit of the final result.
- Flag Z: the final result equals 0.
- Flag V, for add and sub: signed overflow.
- Flag V, for mul: the full 2·WIDTH product differs from the sign-extension of its low half.
- Flag V, for shl: a bit shifted out differs from the resulting sign bit.
- Flag V: 0 for every other opcode.
- Flag C: unsigned carry-out, for add only; 0 for all other opcodes, including sub.
- Examples at W=8:
  - 100+50 gives -106 with flags 1100.
  - 25-50 gives -25 with flags 0100.
  - 50*3 gives -106 with V=1.
- `sticky_v` sets when the output handshake (`out_valid && out_ready`) completes with any lane V=1.
- `sticky_clr` wins over a same-cycle set.

## Timing
- Two register stages:
  - S1 latches the operands and opcode on `in_valid && in_ready`.
  - S2 latches the computed result and flags.
- Latency is 2 cycles from input handshake to `out_valid` when there is no stall. Throughput is 1 transaction/cycle.
- Stall rules:
  - S2 holds while `out_valid && !out_ready`.
  - S1 advances into S2 when S2 is empty or draining.
  - `in_ready = !s1_valid || s2_advance`. This is combinational from `out_ready`; there is no bubble.
- `result` and `flags` stay stable while `out_valid && !out_ready`.
- Reset values: `s1_valid`, `out_valid` and `sticky_v` = 0; `result` and `flags` = 0. `in_ready` is 1 one cycle after reset deasserts (it is combinational from the empty S1).
- Reset asserted mid-flight discards both stages immediately; no partial output.
- Simultaneous input and output handshake with both stages full: S2 takes S1 and S1 takes the new request, all in the same cycle.

## Configuration
- `ALU_VEC_SAT_EN` defined:
  - add, sub, mul and shl saturate on V: positive overflow gives `2^(W-1)-1`, negative overflow gives `-2^(W-1)`.
  - V is still reported.
  - N and Z reflect the saturated value.
  - Example: 100+50 at W=8 gives 127, flags 1000.
- `ALU_VEC_SAT_EN` undefined: wrap-around results as listed under Operation.

## Structure
- Package `alu_vec_pkg`:
  - opcode enum `alu_op_e` with `OP_MUL`, `OP_SUB`, `OP_ADD`, `OP_SHL`, `OP_SRA`, `OP_MIN`, `OP_MAX`, `OP_SET`;
  - flag index constants `FLG_V=3`, `FLG_N=2`, `FLG_Z=1`, `FLG_C=0`.
- Sub-module `alu_vec_lane`: purely combinational, parameter `WIDTH`, one lane's result and flags. Instantiated `LANES` times in a generate loop between S1 and S2.

## Test plan
Configuration for all scenarios: `LANES=4`, `WIDTH=8`.
- add, a={50,100,-1,0}, b={25,50,1,0}, `out_ready=1` -> after 2 cycles result {75,-106,0,0}; flags {0000,1100,0011,0010}; `sticky_v=1`.
- sub a={25,50,-128,7}, b={50,25,1,7} -> {-25,25,127,0}; flags {0100,0000,1000,0010}.
- mul a={10,50,-20,-1}, b={12,3,3,-1} -> {120,-106,-60,1}; V only on lane 1. With `ALU_VEC_SAT_EN` defined, lane 1 gives 127 instead.
- set, `scalar_c`=-50 -> all lanes -50, flags 0100. Then `sticky_clr` -> `sticky_v=0` next cycle.
- Backpressure:
  - three back-to-back requests with `out_ready=0` for 4 cycles -> `in_ready` drops after 2 accepts; results are held stable.
  - after `out_ready` is released -> results emerge in order, one per cycle.
- Assert `rst` with both stages full -> `out_valid=0` immediately. After release, the first new request returns in 2 cycles.

Source files
------------

// File: rtl/alu_vec_pkg.sv
// alu_vec_pkg: shared types and constants for the pipelined vector ALU.
//   alu_op_e : 3-bit opcode, identical for all lanes of a transaction.
//   FLG_*    : bit positions of {V,N,Z,C} inside each lane's 4-bit flag nibble.
// Optional feature macro used by the lane datapath: ALU_VEC_SAT_EN.
package alu_vec_pkg;

    typedef enum logic [2:0] {
        OP_MUL = 3'b000,
        OP_SUB = 3'b001,
        OP_ADD = 3'b010,
        OP_SHL = 3'b011,
        OP_SRA = 3'b100,
        OP_MIN = 3'b101,
        OP_MAX = 3'b110,
        OP_SET = 3'b111
    } alu_op_e;

    localparam int unsigned FLG_V = 3;
    localparam int unsigned FLG_N = 2;
    localparam int unsigned FLG_Z = 1;
    localparam int unsigned FLG_C = 0;

endpackage

// File: rtl/alu_vec_lane.sv
// alu_vec_lane: purely combinational datapath for one signed lane.
// Ports:
//   op   in  alu_op_e     operation
//   a    in  [WIDTH-1:0]  operand A (two's complement)
//   b    in  [WIDTH-1:0]  operand B; low $clog2(WIDTH) bits are the shift count
//   c    in  [WIDTH-1:0]  broadcast value for OP_SET
//   res  out [WIDTH-1:0]  lane result
//   flg  out [3:0]        {V,N,Z,C}
// Macro ALU_VEC_SAT_EN: when defined, add/sub/mul/shl saturate on signed
// overflow (V still reported, N/Z follow the saturated value); otherwise the
// results wrap.
module alu_vec_lane
    import alu_vec_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  alu_op_e          op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] res,
    output logic [3:0]       flg
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH:0]       sum_s;
    logic [WIDTH-1:0]     diff_s;
    logic [2*WIDTH-1:0]   a_ext_s;
    logic [2*WIDTH-1:0]   b_ext_s;
    logic [2*WIDTH-1:0]   prod_s;
    logic [SHW-1:0]       sh_s;
    logic [WIDTH-1:0]     shl_s;
    logic [WIDTH-1:0]     sra_s;
    logic [WIDTH-1:0]     raw_s;
    logic                 ovf_s;
    logic                 ovf_neg_s;
    logic                 carry_s;

    // Candidate results for every opcode; the low half of a product of two
    // sign-extended operands is the exact signed 2W product.
    always_comb begin
        sum_s   = {1'b0, a} + {1'b0, b};
        diff_s  = a - b;
        a_ext_s = {{WIDTH{a[WIDTH-1]}}, a};
        b_ext_s = {{WIDTH{b[WIDTH-1]}}, b};
        prod_s  = a_ext_s * b_ext_s;
        sh_s    = b[SHW-1:0];
        shl_s   = a << sh_s;
        sra_s   = $signed(a) >>> sh_s;
    end

    // Opcode select, overflow detection and overflow direction.
    always_comb begin
        raw_s     = {WIDTH{1'b0}};
        ovf_s     = 1'b0;
        ovf_neg_s = 1'b0;
        carry_s   = 1'b0;
        case (op)
            OP_MUL: begin
                raw_s     = prod_s[WIDTH-1:0];
                ovf_s     = (prod_s != {{WIDTH{prod_s[WIDTH-1]}}, prod_s[WIDTH-1:0]});
                ovf_neg_s = prod_s[2*WIDTH-1];
            end
            OP_SUB: begin
                raw_s     = diff_s;
                ovf_s     = (a[WIDTH-1] != b[WIDTH-1]) && (diff_s[WIDTH-1] != a[WIDTH-1]);
                ovf_neg_s = a[WIDTH-1];
            end
            OP_ADD: begin
                raw_s     = sum_s[WIDTH-1:0];
                ovf_s     = (a[WIDTH-1] == b[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
                ovf_neg_s = a[WIDTH-1];
                carry_s   = sum_s[WIDTH];
            end
            OP_SHL: begin
                raw_s     = shl_s;
                // Shifting back arithmetically recovers a only if every bit
                // pushed out matched the new sign bit.
                ovf_s     = (($signed(shl_s) >>> sh_s) != $signed(a));
                ovf_neg_s = a[WIDTH-1];
            end
            OP_SRA: begin
                raw_s = sra_s;
            end
            OP_MIN: begin
                if ($signed(a) < $signed(b)) begin
                    raw_s = a;
                end else begin
                    raw_s = b;
                end
            end
            OP_MAX: begin
                if ($signed(a) > $signed(b)) begin
                    raw_s = a;
                end else begin
                    raw_s = b;
                end
            end
            OP_SET: begin
                raw_s = c;
            end
            default: begin
                raw_s = {WIDTH{1'b0}};
            end
        endcase
    end

    // Final result (optionally saturated) and flags derived from it.
    always_comb begin
`ifdef ALU_VEC_SAT_EN
        if (ovf_s) begin
            if (ovf_neg_s) begin
                res = SAT_MIN;
            end else begin
                res = SAT_MAX;
            end
        end else begin
            res = raw_s;
        end
`else
        res = raw_s;
`endif
        flg        = 4'b0000;
        flg[FLG_V] = ovf_s;
        flg[FLG_N] = res[WIDTH-1];
        flg[FLG_Z] = (res == {WIDTH{1'b0}});
        flg[FLG_C] = carry_s;
    end

    // Direction and bounds are only consumed by the saturating build.
    logic unused_sat_s;
    assign unused_sat_s = ^{ovf_neg_s, SAT_MAX, SAT_MIN};

endmodule

// File: rtl/alu_vec_pipe.sv
// alu_vec_pipe: two-stage valid/ready pipelined vector ALU, LANES signed
// lanes of WIDTH bits, per-lane {V,N,Z,C} flags and a sticky overflow bit.
// Ports:
//   clk, rst               clock (rising edge), asynchronous active-high reset
//   in_valid / in_ready    request handshake (in_ready combinational)
//   opcode [2:0]           operation for all lanes
//   vec_a, vec_b           operands, lane i at [i*WIDTH +: WIDTH]
//   scalar_c [WIDTH-1:0]   broadcast value for OP_SET
//   out_valid / out_ready  result handshake
//   result                 per-lane result, same packing as operands
//   flags                  per-lane {V,N,Z,C}, lane i at [i*4 +: 4]
//   sticky_v               OR of V over all completed transactions
//   sticky_clr             synchronous clear of sticky_v (wins over a set)
// Macro ALU_VEC_SAT_EN (in alu_vec_lane) selects saturating arithmetic.
module alu_vec_pipe
    import alu_vec_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LANES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [2:0]             opcode,
    input  logic [LANES*WIDTH-1:0] vec_a,
    input  logic [LANES*WIDTH-1:0] vec_b,
    input  logic [WIDTH-1:0]       scalar_c,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] result,
    output logic [LANES*4-1:0]     flags,
    output logic                   sticky_v,
    input  logic                   sticky_clr
);

    logic                   s1_valid_r;
    alu_op_e                s1_op_r;
    logic [LANES*WIDTH-1:0] s1_a_r;
    logic [LANES*WIDTH-1:0] s1_b_r;
    logic [WIDTH-1:0]       s1_c_r;

    logic                   s2_advance_s;
    logic                   in_fire_s;
    logic                   out_fire_s;
    logic                   any_v_s;
    logic [LANES*WIDTH-1:0] lane_res_s;
    logic [LANES*4-1:0]     lane_flg_s;

    // S2 can take new data when it is empty or being drained this cycle.
    assign s2_advance_s = !out_valid || out_ready;
    assign in_ready     = !s1_valid_r || s2_advance_s;
    assign in_fire_s    = in_valid && in_ready;
    assign out_fire_s   = out_valid && out_ready;

    // Stage 1: operand and opcode capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_op_r    <= OP_MUL;
            s1_a_r     <= {(LANES*WIDTH){1'b0}};
            s1_b_r     <= {(LANES*WIDTH){1'b0}};
            s1_c_r     <= {WIDTH{1'b0}};
        end else begin
            if (in_fire_s) begin
                s1_valid_r <= 1'b1;
                s1_op_r    <= alu_op_e'(opcode);
                s1_a_r     <= vec_a;
                s1_b_r     <= vec_b;
                s1_c_r     <= scalar_c;
            end else if (s2_advance_s) begin
                s1_valid_r <= 1'b0;
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < LANES; g++) begin : g_lane
            alu_vec_lane #(
                .WIDTH(WIDTH)
            ) u_lane (
                .op  (s1_op_r),
                .a   (s1_a_r[g*WIDTH +: WIDTH]),
                .b   (s1_b_r[g*WIDTH +: WIDTH]),
                .c   (s1_c_r),
                .res (lane_res_s[g*WIDTH +: WIDTH]),
                .flg (lane_flg_s[g*4 +: 4])
            );
        end
    endgenerate

    // Stage 2: registered result/flags, held while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            result    <= {(LANES*WIDTH){1'b0}};
            flags     <= {(LANES*4){1'b0}};
        end else begin
            if (s2_advance_s) begin
                out_valid <= s1_valid_r;
                if (s1_valid_r) begin
                    result <= lane_res_s;
                    flags  <= lane_flg_s;
                end
            end
        end
    end

    // Overflow summary of the transaction currently presented at the output.
    always_comb begin
        any_v_s = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            any_v_s = any_v_s | flags[i*4 + FLG_V];
        end
    end

    // Sticky overflow: set on a completed output handshake, clear has priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_v <= 1'b0;
        end else begin
            if (sticky_clr) begin
                sticky_v <= 1'b0;
            end else if (out_fire_s && any_v_s) begin
                sticky_v <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_vec_pipe.sv
// tb_alu_vec_pipe: directed self-checking bench for alu_vec_pipe at
// LANES=4, WIDTH=8. Expected values are hand-computed; lanes are listed
// lane 0 first. Honors ALU_VEC_SAT_EN for the saturating expectations.
module tb_alu_vec_pipe;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  opcode;
    logic [31:0] vec_a;
    logic [31:0] vec_b;
    logic [7:0]  scalar_c;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [15:0] flags;
    logic        sticky_v;
    logic        sticky_clr;

    int errors;
    int checks;

    alu_vec_pipe #(
        .WIDTH(8),
        .LANES(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .opcode     (opcode),
        .vec_a      (vec_a),
        .vec_b      (vec_b),
        .scalar_c   (scalar_c),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .flags      (flags),
        .sticky_v   (sticky_v),
        .sticky_clr (sticky_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] p4(input logic [7:0] l0, input logic [7:0] l1,
                                       input logic [7:0] l2, input logic [7:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    function automatic logic [15:0] f4(input logic [3:0] l0, input logic [3:0] l1,
                                       input logic [3:0] l2, input logic [3:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request into an empty pipe with out_ready high; capture the
    // output two cycles later, then let it drain.
    task automatic send_one(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [7:0] c, output logic v, output logic [31:0] r,
                            output logic [15:0] f);
        opcode    = op;
        vec_a     = a;
        vec_b     = b;
        scalar_c  = c;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        v = out_valid;
        r = result;
        f = flags;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        checks++;
        if (out_valid !== 1'b0 || result !== 32'h0 || flags !== 16'h0 || sticky_v !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: got v=%b r=%h f=%h s=%b, need 0/0/0/0",
                     out_valid, result, flags, sticky_v);
        end
        tick();
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b need 1", in_ready);
        end
    endtask

    task automatic test_add();
        logic v;
        logic [31:0] r;
        logic [15:0] f;
        logic [31:0] er;
        logic [15:0] ef;
`ifdef ALU_VEC_SAT_EN
        er = p4(8'd75, 8'd127, 8'd0, 8'd0);
        ef = f4(4'b0000, 4'b1000, 4'b0011, 4'b0010);
`else
        er = p4(8'd75, 8'h96, 8'd0, 8'd0);
        ef = f4(4'b0000, 4'b1100, 4'b0011, 4'b0010);
`endif
        send_one(3'b010, p4(8'd50, 8'd100, 8'hFF, 8'd0), p4(8'd25, 8'd50, 8'd1, 8'd0), 8'd0, v, r, f);
        checks++;
        if (v !== 1'b1) begin errors++; $display("FAIL add_valid: got %b need 1", v); end
        checks++;
        if (r !== er) begin errors++; $display("FAIL add_result: got %h need %h", r, er); end
        checks++;
        if (f !== ef) begin errors++; $display("FAIL add_flags: got %h need %h", f, ef); end
        checks++;
        if (sticky_v !== 1'b1) begin errors++; $display("FAIL add_sticky: got %b need 1", sticky_v); end
    endtask

    task automatic test_sub();
        logic v;
        logic [31:0] r;
        logic [15:0] f;
        logic [31:0] er;
        logic [15:0] ef;
`ifdef ALU_VEC_SAT_EN
        er = p4(8'hE7, 8'd25, 8'h80, 8'd0);
        ef = f4(4'b0100, 4'b0000, 4'b1100, 4'b0010);
`else
        er = p4(8'hE7, 8'd25, 8'd127, 8'd0);
        ef = f4(4'b0100, 4'b0000, 4'b1000, 4'b0010);
`endif
        send_one(3'b001, p4(8'd25, 8'd50, 8'h80, 8'd7), p4(8'd50, 8'd25, 8'd1, 8'd7), 8'd0, v, r, f);
        checks++;
        if (v !== 1'b1 || r !== er) begin errors++; $display("FAIL sub_result: got v=%b %h need %h", v, r, er); end
        checks++;
        if (f !== ef) begin errors++; $display("FAIL sub_flags: got %h need %h", f, ef); end
    endtask

    task automatic test_mul();
        logic v;
        logic [31:0] r;
        logic [15:0] f;
        logic [31:0] er;
        logic [15:0] ef;
`ifdef ALU_VEC_SAT_EN
        er = p4(8'd120, 8'd127, 8'hC4, 8'd1);
        ef = f4(4'b0000, 4'b1000, 4'b0100, 4'b0000);
`else
        er = p4(8'd120, 8'h96, 8'hC4, 8'd1);
        ef = f4(4'b0000, 4'b1100, 4'b0100, 4'b0000);
`endif
        send_one(3'b000, p4(8'd10, 8'd50, 8'hEC, 8'hFF), p4(8'd12, 8'd3, 8'd3, 8'hFF), 8'd0, v, r, f);
        checks++;
        if (v !== 1'b1 || r !== er) begin errors++; $display("FAIL mul_result: got v=%b %h need %h", v, r, er); end
        checks++;
        if (f !== ef) begin errors++; $display("FAIL mul_flags: got %h need %h", f, ef); end
    endtask

    task automatic test_shifts();
        logic v;
        logic [31:0] r;
        logic [15:0] f;
        logic [31:0] er;
        logic [15:0] ef;
        // shl: 1<<3, 64<<1 (overflow), -1<<7 (no overflow), 3<<(9&7)
`ifdef ALU_VEC_SAT_EN
        er = p4(8'd8, 8'd127, 8'h80, 8'd6);
        ef = f4(4'b0000, 4'b1000, 4'b0100, 4'b0000);
`else
        er = p4(8'd8, 8'h80, 8'h80, 8'd6);
        ef = f4(4'b0000, 4'b1100, 4'b0100, 4'b0000);
`endif
        send_one(3'b011, p4(8'd1, 8'd64, 8'hFF, 8'd3), p4(8'd3, 8'd1, 8'd7, 8'd9), 8'd0, v, r, f);
        checks++;
        if (v !== 1'b1 || r !== er) begin errors++; $display("FAIL shl_result: got v=%b %h need %h", v, r, er); end
        checks++;
        if (f !== ef) begin errors++; $display("FAIL shl_flags: got %h need %h", f, ef); end
        // sra: -128>>>3, 64>>>2, -1>>>7, 100>>>(8&7)
        er = p4(8'hF0, 8'd16, 8'hFF, 8'd100);
        ef = f4(4'b0100, 4'b0000, 4'b0100, 4'b0000);
        send_one(3'b100, p4(8'h80, 8'd64, 8'hFF, 8'd100), p4(8'd3, 8'd2, 8'd7, 8'd8), 8'd0, v, r, f);
        checks++;
        if (v !== 1'b1 || r !== er) begin errors++; $display("FAIL sra_result: got v=%b %h need %h", v, r, er); end
        checks++;
        if (f !== ef) begin errors++; $display("FAIL sra_flags: got %h need %h", f, ef); end
    endtask

    task automatic test_minmax();
        logic v;
        logic [31:0] r;
        logic [15:0] f;
        logic [31:0] a;
        logic [31:0] b;
        a = p4(8'd5, 8'hFB, 8'd0, 8'h80);
        b = p4(8'hFD, 8'd3, 8'd1, 8'h80);
        send_one(3'b101, a, b, 8'd0, v, r, f);
        checks++;
        if (v !== 1'b1 || r !== p4(8'hFD, 8'hFB, 8'd0, 8'h80)) begin
            errors++; $display("FAIL min_result: got v=%b %h need %h", v, r, p4(8'hFD, 8'hFB, 8'd0, 8'h80));
        end
        checks++;
        if (f !== f4(4'b0100, 4'b0100, 4'b0010, 4'b0100)) begin
            errors++; $display("FAIL min_flags: got %h need %h", f, f4(4'b0100, 4'b0100, 4'b0010, 4'b0100));
        end
        send_one(3'b110, a, b, 8'd0, v, r, f);
        checks++;
        if (v !== 1'b1 || r !== p4(8'd5, 8'd3, 8'd1, 8'h80)) begin
            errors++; $display("FAIL max_result: got v=%b %h need %h", v, r, p4(8'd5, 8'd3, 8'd1, 8'h80));
        end
        checks++;
        if (f !== f4(4'b0000, 4'b0000, 4'b0000, 4'b0100)) begin
            errors++; $display("FAIL max_flags: got %h need %h", f, f4(4'b0000, 4'b0000, 4'b0000, 4'b0100));
        end
    endtask

    task automatic test_set_and_clear();
        logic v;
        logic [31:0] r;
        logic [15:0] f;
        send_one(3'b111, p4(8'd1, 8'd2, 8'd3, 8'd4), p4(8'd9, 8'd9, 8'd9, 8'd9), 8'hCE, v, r, f);
        checks++;
        if (v !== 1'b1 || r !== 32'hCECECECE) begin errors++; $display("FAIL set_result: got v=%b %h need cecececE", v, r); end
        checks++;
        if (f !== 16'h4444) begin errors++; $display("FAIL set_flags: got %h need 4444", f); end
        checks++;
        if (sticky_v !== 1'b1) begin errors++; $display("FAIL sticky_hold: got %b need 1", sticky_v); end
        sticky_clr = 1'b1;
        tick();
        sticky_clr = 1'b0;
        checks++;
        if (sticky_v !== 1'b0) begin errors++; $display("FAIL sticky_clear: got %b need 0", sticky_v); end
    endtask

    // Overflowing result held at the output, then drained in the same cycle
    // that sticky_clr is asserted: the clear must win.
    task automatic test_clear_wins();
        opcode    = 3'b010;
        vec_a     = p4(8'd100, 8'd100, 8'd100, 8'd100);
        vec_b     = p4(8'd50, 8'd50, 8'd50, 8'd50);
        scalar_c  = 8'd0;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b1 || flags[3] !== 1'b1) begin
            errors++; $display("FAIL clrwin_setup: got v=%b flags=%h need v=1 V=1", out_valid, flags);
        end
        out_ready  = 1'b1;
        sticky_clr = 1'b1;
        tick();
        sticky_clr = 1'b0;
        checks++;
        if (sticky_v !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL clear_wins: got sticky=%b v=%b need 0/0", sticky_v, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] rc;
        ra = p4(8'd1, 8'd2, 8'd3, 8'd4);
        rb = p4(8'd11, 8'd21, 8'd31, 8'd41);
        rc = p4(8'd10, 8'd11, 8'd12, 8'd13);
        opcode    = 3'b010;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        vec_a = p4(8'd1, 8'd2, 8'd3, 8'd4);
        vec_b = 32'h0;
        tick();
        vec_a = p4(8'd10, 8'd20, 8'd30, 8'd40);
        vec_b = p4(8'd1, 8'd1, 8'd1, 8'd1);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_second_accept: got %b need 1", in_ready); end
        tick();
        vec_a = p4(8'd5, 8'd6, 8'd7, 8'd8);
        vec_b = p4(8'd5, 8'd5, 8'd5, 8'd5);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            errors++; $display("FAIL bp_full: got in_ready=%b out_valid=%b need 0/1", in_ready, out_valid);
        end
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || result !== ra || in_ready !== 1'b0) begin
                errors++; $display("FAIL bp_hold: got v=%b r=%h rdy=%b need 1/%h/0", out_valid, result, in_ready, ra);
            end
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b need 1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || result !== rb) begin
            errors++; $display("FAIL bp_order_b: got v=%b r=%h need 1/%h", out_valid, result, rb);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || result !== rc) begin
            errors++; $display("FAIL bp_order_c: got v=%b r=%h need 1/%h", out_valid, result, rc);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b need 0", out_valid); end
    endtask

    task automatic test_reset_midflight();
        logic v;
        logic [31:0] r;
        logic [15:0] f;
        opcode    = 3'b010;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        vec_a = p4(8'd1, 8'd1, 8'd1, 8'd1);
        vec_b = p4(8'd1, 8'd1, 8'd1, 8'd1);
        tick();
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++; $display("FAIL rst_setup: got v=%b rdy=%b need 1/0", out_valid, in_ready);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || result !== 32'h0) begin
            errors++; $display("FAIL rst_midflight: got v=%b r=%h need 0/0", out_valid, result);
        end
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_no_stale: got %b need 0", out_valid); end
        send_one(3'b001, p4(8'd9, 8'd8, 8'd7, 8'd6), p4(8'd1, 8'd1, 8'd1, 8'd1), 8'd0, v, r, f);
        checks++;
        if (v !== 1'b1 || r !== p4(8'd8, 8'd7, 8'd6, 8'd5)) begin
            errors++; $display("FAIL rst_first_req: got v=%b %h need 1/%h", v, r, p4(8'd8, 8'd7, 8'd6, 8'd5));
        end
    endtask

    initial begin
        errors     = 0;
        checks     = 0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        opcode     = 3'b000;
        vec_a      = 32'h0;
        vec_b      = 32'h0;
        scalar_c   = 8'h0;
        sticky_clr = 1'b0;
        rst        = 1'b0;
        test_reset();
        test_add();
        test_sub();
        test_mul();
        test_shifts();
        test_minmax();
        test_set_and_clear();
        test_clear_wins();
        test_back_to_back();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
